dense_layer_engine: RTL and testbench

- Parametrised successor to the fixed 10-output MNIST accelerator.
- Streams one input pixel per cycle from the external image memory using its own address counter, and reads a wide weight word that holds one weight per class.
- Computes NUM_CLASSES signed dot products in parallel.
- Adds a start/busy/done handshake, latched results, and an optional argmax output.

---
 rtl/dense_layer_if.sv | 31 +++
 rtl/dense_layer_engine.sv | 146 ++++++++++++++
 tb/tb_dense_layer_engine.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/dense_layer_if.sv
// dense_layer_if: handshake, memory-read and result bus of dense_layer_engine.
// The master side (the system) drives start and answers the memory reads
// (image, wdata). The slave side (the engine) drives the address, the
// status flags and the latched results.
interface dense_layer_if #(
    parameter int NUM_CLASSES = 10,
    parameter int PIX_W       = 32,
    parameter int W_W         = 8,
    parameter int ACC_W       = 32,
    parameter int ADDR_W      = 32,
    parameter int CLS_W       = 4
) ();
    logic                           start;
    logic signed [PIX_W-1:0]        image;
    logic [ADDR_W-1:0]              counter1;
    logic [NUM_CLASSES*W_W-1:0]     wdata;
    logic                           busy;
    logic                           done;
    logic [NUM_CLASSES*ACC_W-1:0]   results;
    logic [CLS_W-1:0]               class_out;

    modport master (
        output start, image, wdata,
        input  counter1, busy, done, results, class_out
    );

    modport slave (
        input  start, image, wdata,
        output counter1, busy, done, results, class_out
    );
endinterface

// File: rtl/dense_layer_engine.sv
// dense_layer_engine: streams NUM_INPUTS pixels (one per cycle) from the
// image memory and accumulates NUM_CLASSES signed dot products in parallel
// against a wide weight word. Results are latched and announced by a
// one-cycle done pulse.
// Optional feature: define DENSE_ARGMAX_EN to register the argmax of the
// results on class_out (tie -> lowest index); otherwise class_out is 0.
module dense_layer_engine #(
    parameter int NUM_CLASSES = 10,
    parameter int NUM_INPUTS  = 784,
    parameter int PIX_W       = 32,
    parameter int W_W         = 8,
    parameter int ACC_W       = 32,
    parameter int ADDR_W      = 32,
    parameter int CLS_W       = 4
) (
    input  logic         clk,
    input  logic         reset,
    dense_layer_if.slave bus
);

    localparam int                PROD_W    = PIX_W + W_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t                         r_state;
    logic [ADDR_W-1:0]              r_counter1;
    logic                           r_busy;
    logic                           r_done;
    logic signed [ACC_W-1:0]        r_acc [NUM_CLASSES];
    logic [NUM_CLASSES*ACC_W-1:0]   r_results;
    logic signed [ACC_W-1:0]        w_term [NUM_CLASSES];

    // One signed multiplier per class. The product is kept at full
    // PIX_W+W_W precision and then resized to the accumulator width:
    // a size cast of a signed value sign-extends when widening and keeps
    // the low bits when narrowing, which is exactly modulo-2^ACC_W math.
    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_mac
        logic signed [PROD_W-1:0] w_prod;
        assign w_prod    = PROD_W'(bus.image) * PROD_W'($signed(bus.wdata[k*W_W +: W_W]));
        assign w_term[k] = ACC_W'(w_prod);
    end

    // Control FSM, address counter, accumulators and result latch.
    // NOTE: every register here is assigned with <= so all of them sample
    // the pre-edge values; mixing in = would make ordering matter.
    // NOTE: the accumulator array is a handful of flops, not a RAM, so it is
    // reset with everything else; a true memory would be left unreset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_counter1 <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_results  <= '0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                r_acc[k] <= '0;
            end
        end else begin
            // done is high only for the cycle after the FINISH edge
            r_done <= (r_state == FINISH);
            case (r_state)
                IDLE: begin
                    r_counter1 <= '0;
                    // busy rises with the accepted start and otherwise drops
                    r_busy     <= bus.start;
                    if (bus.start) begin
                        for (int k = 0; k < NUM_CLASSES; k++) begin
                            r_acc[k] <= '0;
                        end
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_busy <= 1'b1;
                    for (int k = 0; k < NUM_CLASSES; k++) begin
                        r_acc[k] <= r_acc[k] + w_term[k];
                    end
                    if (r_counter1 == LAST_ADDR) begin
                        r_counter1 <= '0;
                        r_state    <= FINISH;
                    end else begin
                        r_counter1 <= r_counter1 + 1'b1;
                    end
                end
                FINISH: begin
                    r_busy     <= 1'b1;
                    r_counter1 <= '0;
                    for (int k = 0; k < NUM_CLASSES; k++) begin
                        r_results[k*ACC_W +: ACC_W] <= r_acc[k];
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state    <= IDLE;
                    r_counter1 <= '0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

`ifdef DENSE_ARGMAX_EN
    logic [CLS_W-1:0]        r_class_out;
    logic [CLS_W-1:0]        w_argmax;
    logic signed [ACC_W-1:0] w_best;

    // Linear argmax over the final accumulators; strict > keeps the lowest
    // index on ties.
    // NOTE: both outputs get a default before the loop so no path leaves
    // them unassigned, which would otherwise infer a latch.
    always_comb begin
        w_argmax = '0;
        w_best   = r_acc[0];
        for (int k = 1; k < NUM_CLASSES; k++) begin
            if (r_acc[k] > w_best) begin
                w_best   = r_acc[k];
                w_argmax = CLS_W'(k);
            end
        end
    end

    // class_out is latched alongside results so both change on done only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_class_out <= '0;
        end else if (r_state == FINISH) begin
            r_class_out <= w_argmax;
        end
    end

    assign bus.class_out = r_class_out;
`else
    assign bus.class_out = '0;
`endif

    assign bus.counter1 = r_counter1;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.results  = r_results;

endmodule

// File: tb/tb_dense_layer_engine.sv
// tb_dense_layer_engine: randomized and directed inference runs checked
// against a plain-arithmetic dot-product / argmax reference model.
// Works with or without DENSE_ARGMAX_EN defined.
module tb_dense_layer_engine;

    localparam int NC     = 10;
    localparam int NI     = 4;
    localparam int PIX_W  = 32;
    localparam int W_W    = 8;
    localparam int ACC_W  = 32;
    localparam int ADDR_W = 32;
    localparam int CLS_W  = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dense_layer_if #(
        .NUM_CLASSES(NC), .PIX_W(PIX_W), .W_W(W_W),
        .ACC_W(ACC_W), .ADDR_W(ADDR_W), .CLS_W(CLS_W)
    ) bus ();

    dense_layer_engine #(
        .NUM_CLASSES(NC), .NUM_INPUTS(NI), .PIX_W(PIX_W), .W_W(W_W),
        .ACC_W(ACC_W), .ADDR_W(ADDR_W), .CLS_W(CLS_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // External image and weight memories, read combinationally at counter1
    logic signed [PIX_W-1:0] img_mem [NI];
    logic signed [W_W-1:0]   wt_mem  [NI][NC];

    always_comb begin
        bus.image = '0;
        bus.wdata = '0;
        if (bus.counter1 < NI) begin
            bus.image = img_mem[bus.counter1[1:0]];
            for (int k = 0; k < NC; k++) begin
                bus.wdata[k*W_W +: W_W] = wt_mem[bus.counter1[1:0]][k];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: exact dot products, wrapped to ACC_W bits
    logic [ACC_W-1:0] exp_res [NC];
    int               exp_cls;

    task automatic compute_model();
        longint s;
        longint best;
        for (int k = 0; k < NC; k++) begin
            s = 0;
            for (int i = 0; i < NI; i++) begin
                s += longint'(img_mem[i]) * longint'(wt_mem[i][k]);
            end
            exp_res[k] = s[ACC_W-1:0];
        end
        exp_cls = 0;
        best    = longint'($signed(exp_res[0]));
        for (int k = 1; k < NC; k++) begin
            if (longint'($signed(exp_res[k])) > best) begin
                best    = longint'($signed(exp_res[k]));
                exp_cls = k;
            end
        end
`ifndef DENSE_ARGMAX_EN
        exp_cls = 0;
`endif
    endtask

    task automatic check_results(input string tag);
        for (int k = 0; k < NC; k++) begin
            check($sformatf("%s res%0d", tag, k), bus.results[k*ACC_W +: ACC_W], exp_res[k]);
        end
        check({tag, " class_out"}, bus.class_out, exp_cls);
    endtask

    // One start pulse; optional extra start pulse mid-run that must be ignored
    task automatic run_inference(input string tag, input bit mid_start);
        int n;
        bit seen;
        logic [NC*ACC_W-1:0] prev;
        prev = bus.results;
        compute_model();
        @(negedge clk);
        bus.start = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            bus.start = mid_start && (n == 2);
            if (n <= NI) begin
                check($sformatf("%s counter1@%0d", tag, n), bus.counter1, n - 1);
                check($sformatf("%s busy@%0d", tag, n), bus.busy, 1);
            end
            if (n == 3) check({tag, " results held mid-run"}, bus.results, prev);
            if (bus.done) seen = 1'b1;
        end
        check({tag, " done latency"}, n, NI + 2);
        check_results(tag);
        check({tag, " busy with done"}, bus.busy, 1);
        @(negedge clk);
        check({tag, " done one cycle"}, bus.done, 0);
        check({tag, " busy released"}, bus.busy, 0);
        check({tag, " counter1 idle"}, bus.counter1, 0);
    endtask

    initial begin
        int pulses;
        int found;
        reset     = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < NI; i++) begin
            img_mem[i] = '0;
            for (int k = 0; k < NC; k++) wt_mem[i][k] = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset results", bus.results, 0);
        check("reset counter1", bus.counter1, 0);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset class_out", bus.class_out, 0);

        // Ramp weights: results[k] = 4k, argmax 9
        for (int i = 0; i < NI; i++) begin
            img_mem[i] = 1;
            for (int k = 0; k < NC; k++) wt_mem[i][k] = W_W'(k);
        end
        run_inference("ramp", 1'b0);

        // Negative pixels: -24 / 12 / zeros
        for (int i = 0; i < NI; i++) begin
            img_mem[i] = -3;
            for (int k = 0; k < NC; k++) wt_mem[i][k] = '0;
            wt_mem[i][0] = 2;
            wt_mem[i][1] = -1;
        end
        run_inference("neg", 1'b0);

        // Tie between classes 3 and 7 -> lowest index wins
        for (int i = 0; i < NI; i++) begin
            img_mem[i] = (i == 0) ? 1 : 0;
            for (int k = 0; k < NC; k++) wt_mem[i][k] = 1;
        end
        wt_mem[0][3] = 5;
        wt_mem[0][7] = 5;
        run_inference("tie", 1'b0);

        // Random full-range data, some runs with an ignored mid-run start
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NI; i++) begin
                img_mem[i] = PIX_W'($urandom);
                for (int k = 0; k < NC; k++) wt_mem[i][k] = W_W'($urandom);
            end
            run_inference($sformatf("rand%0d", r), r[0]);
        end

        // start held high: done every NI+2 cycles
        compute_model();
        pulses = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                check($sformatf("held done@%0d period", n), n % (NI + 2), 0);
                check_results("held");
            end
        end
        check("held pulse count", pulses, 3);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);

        // Reset in the middle of a run
        for (int i = 0; i < NI; i++) begin
            img_mem[i] = PIX_W'($urandom);
            for (int k = 0; k < NC; k++) wt_mem[i][k] = W_W'($urandom);
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        found = 0;
        for (int n = 0; n < 10 && found == 0; n++) begin
            if (bus.counter1 == 2) found = 1;
            else @(negedge clk);
        end
        check("abort reached counter1=2", found, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort counter1", bus.counter1, 0);
        check("abort busy", bus.busy, 0);
        check("abort done", bus.done, 0);
        check("abort results", bus.results, 0);
        check("abort class_out", bus.class_out, 0);
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("abort no done", pulses, 0);
        run_inference("post-abort", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
